i2c_burst_write_master: RTL and testbench

//  Parametrised I2C write master for sensor/camera register init. Sends START, 7-bit slave

---
 rtl/i2c_pkg.sv | 31 +++
 rtl/i2c_tick_gen.sv | 26 ++
 rtl/i2c_burst_write_master.sv | 163 ++++++++++++++++
 tb/tb_i2c_burst_write_master.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and sizing helpers for the I2C burst write master.
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_BIT,
      ST_ACK,
      ST_STOP,
      ST_DELAY,
      ST_DONE
   } state_t;

   localparam logic [1:0] PH0 = 2'd0;
   localparam logic [1:0] PH1 = 2'd1;
   localparam logic [1:0] PH2 = 2'd2;
   localparam logic [1:0] PH3 = 2'd3;

   // Widest payload supported (2 reg-addr + 4 data bytes); delay code is its all-ones slice.
   localparam int unsigned MAX_PAYLOAD_W = 48;
   localparam logic [MAX_PAYLOAD_W-1:0] DELAY_CODE = '1;

   function automatic int unsigned payload_w(input int unsigned ra_bytes, input int unsigned d_bytes);
      return 8 * (ra_bytes + d_bytes);
   endfunction

   function automatic int unsigned nbytes(input int unsigned ra_bytes, input int unsigned d_bytes);
      return 1 + ra_bytes + d_bytes;
   endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// SCL quarter-period tick divider; cleared while disabled, frozen during clock stretch.
module i2c_tick_gen #(
   parameter int unsigned CLK_DIV = 125
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic freeze,
   output logic tick_c
);

   localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DW-1:0] div;

   assign tick_c = enable && !freeze && (div == DW'(CLK_DIV - 1));

   always_ff @(posedge clk) begin
      if (reset || !enable) begin
         div <= '0;
      end else if (!freeze) begin
         div <= tick_c ? '0 : div + DW'(1);
      end
   end

endmodule

// File: rtl/i2c_burst_write_master.sv
// I2C write master: START, address+W, register/data bytes, STOP; NACK abort, stretch and delay command.
module i2c_burst_write_master
   import i2c_pkg::*;
#(
   parameter int unsigned CLK_DIV        = 125,
   parameter int unsigned REG_ADDR_BYTES = 1,
   parameter int unsigned DATA_BYTES     = 1,
   parameter int unsigned DELAY_TICKS    = 200,
   localparam int unsigned PAYLOAD_W     = payload_w(REG_ADDR_BYTES, DATA_BYTES)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [6:0]           sl_addr,
   input  logic [PAYLOAD_W-1:0] payload,
   input  logic                 sda_in,
   input  logic                 scl_in,
   output logic                 scl_oe,
   output logic                 sda_oe,
   output logic                 busy,
   output logic                 done,
   output logic                 nack
);

   localparam int unsigned NBYTES    = nbytes(REG_ADDR_BYTES, DATA_BYTES);
   localparam int unsigned BIW       = $clog2(NBYTES + 1);
   localparam int unsigned DLY_TOTAL = 4 * DELAY_TICKS;
   localparam int unsigned DCW       = $clog2(DLY_TOTAL);

   state_t               state;
   logic [1:0]           phase;
   logic [2:0]           bit_idx;
   logic [BIW-1:0]       byte_idx;
   logic [7:0]           shreg;
   logic [PAYLOAD_W-1:0] pay_sr;
   logic [DCW-1:0]       delay_cnt;
   logic                 tick_c;
   logic                 tick_en_c;
   logic                 freeze_c;

   assign tick_en_c = (state != ST_IDLE) && (state != ST_DONE);
   // A slave holding SCL low during the released phase stalls the bit.
   assign freeze_c  = ((state == ST_BIT) || (state == ST_ACK)) && (phase == PH1) && !scl_in;

   i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
      .clk    (clk),
      .reset  (reset),
      .enable (tick_en_c),
      .freeze (freeze_c),
      .tick_c (tick_c)
   );

   // Line enables are updated on the same edge as the phase they belong to.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         phase     <= PH0;
         bit_idx   <= '0;
         byte_idx  <= '0;
         shreg     <= '0;
         pay_sr    <= '0;
         delay_cnt <= '0;
         scl_oe    <= 1'b0;
         sda_oe    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         nack      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start && !busy) begin
            pay_sr    <= payload;
            shreg     <= {sl_addr, 1'b0};
            bit_idx   <= '0;
            byte_idx  <= '0;
            phase     <= PH0;
            delay_cnt <= '0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b1;
            nack      <= 1'b0;
            state     <= (payload == DELAY_CODE[PAYLOAD_W-1:0]) ? ST_DELAY : ST_START;
         end else if (tick_c || (state == ST_DONE)) begin
            case (state)
               ST_START: begin
                  unique case (phase)
                     PH0:     begin phase <= PH1; sda_oe <= 1'b1; end
                     PH1:     begin phase <= PH2; scl_oe <= 1'b1; end
                     default: begin
                        state  <= ST_BIT;
                        phase  <= PH0;
                        sda_oe <= ~shreg[7];
                     end
                  endcase
               end
               ST_BIT: begin
                  unique case (phase)
                     PH0: begin phase <= PH1; scl_oe <= 1'b0; end
                     PH1: phase <= PH2;
                     PH2: begin phase <= PH3; scl_oe <= 1'b1; end
                     PH3: begin
                        phase <= PH0;
                        if (bit_idx == 3'd7) begin
                           state   <= ST_ACK;
                           sda_oe  <= 1'b0;
                           bit_idx <= '0;
                        end else begin
                           bit_idx <= bit_idx + 3'd1;
                           shreg   <= {shreg[6:0], 1'b0};
                           sda_oe  <= ~shreg[6];
                        end
                     end
                  endcase
               end
               ST_ACK: begin
                  unique case (phase)
                     PH0: begin phase <= PH1; scl_oe <= 1'b0; end
                     PH1: phase <= PH2;
                     PH2: begin phase <= PH3; scl_oe <= 1'b1; nack <= sda_in; end
                     PH3: begin
                        phase <= PH0;
                        // Abort on NACK only once SCL is low again, so SDA never moves under a high SCL.
                        if (nack || (byte_idx == BIW'(NBYTES - 1))) begin
                           state  <= ST_STOP;
                           sda_oe <= 1'b1;
                        end else begin
                           state    <= ST_BIT;
                           byte_idx <= byte_idx + BIW'(1);
                           shreg    <= pay_sr[PAYLOAD_W-1 -: 8];
                           pay_sr   <= pay_sr << 8;
                           sda_oe   <= ~pay_sr[PAYLOAD_W-1];
                        end
                     end
                  endcase
               end
               ST_STOP: begin
                  unique case (phase)
                     PH0:     begin phase <= PH1; scl_oe <= 1'b0; end
                     PH1:     begin phase <= PH2; sda_oe <= 1'b0; end
                     default: begin
                        state <= ST_DONE;
                        phase <= PH0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  endcase
               end
               ST_DELAY: begin
                  if (delay_cnt == DCW'(DLY_TOTAL - 1)) begin
                     state <= ST_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     delay_cnt <= delay_cnt + DCW'(1);
                  end
               end
               ST_DONE: state <= ST_IDLE;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_burst_write_master.sv
// Directed bench: two master instances (1+1 and 2+2 byte payloads) on a modelled open-drain bus with an ACKing slave.
module tb_i2c_burst_write_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_w  [2];
   logic [6:0]  sl_addr;
   logic [15:0] payload0;
   logic [31:0] payload1;
   logic        sda_in_w [2];
   logic        scl_in_w [2];
   logic        scl_oe_w [2];
   logic        sda_oe_w [2];
   logic        busy_w   [2];
   logic        done_w   [2];
   logic        nack_w   [2];

   // Slave / bus model state
   logic        ack_drv     [2];
   int          stretch_cnt [2];
   int          stretch_at  [2];
   int          nack_byte   [2];
   logic        prev_scl    [2];
   logic        prev_sda    [2];
   logic        prev_oe     [2];
   int          rel_cnt     [2];
   int          bitcnt      [2];
   logic [7:0]  cur         [2];
   logic [7:0]  cap         [2][8];
   logic        ackbit      [2][8];
   int          ncap        [2];
   logic        stop_seen   [2];

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  exp_b [5];

   always #5 clk = ~clk;

   i2c_burst_write_master #(.CLK_DIV(4), .REG_ADDR_BYTES(1), .DATA_BYTES(1), .DELAY_TICKS(200)) dut0 (
      .clk(clk), .reset(reset), .start(start_w[0]), .sl_addr(sl_addr), .payload(payload0),
      .sda_in(sda_in_w[0]), .scl_in(scl_in_w[0]), .scl_oe(scl_oe_w[0]), .sda_oe(sda_oe_w[0]),
      .busy(busy_w[0]), .done(done_w[0]), .nack(nack_w[0])
   );

   i2c_burst_write_master #(.CLK_DIV(4), .REG_ADDR_BYTES(2), .DATA_BYTES(2), .DELAY_TICKS(200)) dut1 (
      .clk(clk), .reset(reset), .start(start_w[1]), .sl_addr(sl_addr), .payload(payload1),
      .sda_in(sda_in_w[1]), .scl_in(scl_in_w[1]), .scl_oe(scl_oe_w[1]), .sda_oe(sda_oe_w[1]),
      .busy(busy_w[1]), .done(done_w[1]), .nack(nack_w[1])
   );

   for (genvar g = 0; g < 2; g++) begin : g_pad
      assign scl_in_w[g] = !scl_oe_w[g] && (stretch_cnt[g] == 0);
      assign sda_in_w[g] = !sda_oe_w[g] && !ack_drv[g];
   end

   // Bus monitor and slave: decodes bytes on SCL rise, ACKs on SCL fall, optionally stretches one bit.
   always @(negedge clk) begin : mon
      logic scl_l;
      logic sda_l;
      for (int g = 0; g < 2; g++) begin
         if (reset) begin
            ack_drv[g] = 1'b0; stretch_cnt[g] = 0; rel_cnt[g] = 0; bitcnt[g] = 0;
            ncap[g] = 0; stop_seen[g] = 1'b0; cur[g] = 8'h00;
            prev_scl[g] = 1'b1; prev_sda[g] = 1'b1; prev_oe[g] = 1'b0;
         end else begin
            if (stretch_cnt[g] > 0) stretch_cnt[g] = stretch_cnt[g] - 1;
            if (prev_oe[g] && !scl_oe_w[g]) begin
               if (rel_cnt[g] == stretch_at[g]) stretch_cnt[g] = 10;
               rel_cnt[g] = rel_cnt[g] + 1;
            end
            prev_oe[g] = scl_oe_w[g];
            scl_l = !scl_oe_w[g] && (stretch_cnt[g] == 0);
            sda_l = !sda_oe_w[g] && !ack_drv[g];
            if (prev_scl[g] && scl_l && prev_sda[g] && !sda_l) begin
               ncap[g] = 0; bitcnt[g] = 0; rel_cnt[g] = 0; stop_seen[g] = 1'b0;
            end else if (prev_scl[g] && scl_l && !prev_sda[g] && sda_l) begin
               stop_seen[g] = 1'b1;
            end
            if (!prev_scl[g] && scl_l) begin
               if (bitcnt[g] == 8) begin
                  if (ncap[g] < 8) begin
                     cap[g][ncap[g]]    = cur[g];
                     ackbit[g][ncap[g]] = sda_l;
                  end
                  ncap[g]   = ncap[g] + 1;
                  bitcnt[g] = 0;
               end else begin
                  cur[g]    = {cur[g][6:0], sda_l};
                  bitcnt[g] = bitcnt[g] + 1;
               end
            end
            if (prev_scl[g] && !scl_l)
               ack_drv[g] = (bitcnt[g] == 8) && (ncap[g] != nack_byte[g]);
            prev_scl[g] = scl_l;
            prev_sda[g] = !sda_oe_w[g] && !ack_drv[g];
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Accept one request on instance g; lat = clks from the accept edge to the done pulse.
   task automatic run_xfer(input string tag, input int g, input int poke_at,
                           output int lat, output logic act);
      logic seen;
      @(negedge clk); start_w[g] = 1'b1;
      @(negedge clk); start_w[g] = 1'b0;
      check_eq({tag, "_busy_acc"}, busy_w[g], 1'b1);
      check_eq({tag, "_nack_acc"}, nack_w[g], 1'b0);
      lat = 0; seen = 1'b0; act = 1'b0;
      while (lat < 6000 && !seen) begin
         @(negedge clk);
         lat++;
         if (lat == poke_at)     start_w[g] = 1'b1;
         if (lat == poke_at + 1) start_w[g] = 1'b0;
         if (done_w[g]) seen = 1'b1;
         act = act | scl_oe_w[g] | sda_oe_w[g];
      end
      check_eq({tag, "_done_seen"}, seen, 1'b1);
      check_eq({tag, "_busy_done"}, busy_w[g], 1'b0);
   endtask

   task automatic check_bus(input string tag, input int g, input int nexp, input logic last_ack);
      check_eq({tag, "_nbytes"}, ncap[g], nexp);
      for (int i = 0; i < nexp; i++) begin
         check_eq($sformatf("%s_byte%0d", tag, i), cap[g][i], exp_b[i]);
         check_eq($sformatf("%s_ack%0d", tag, i), ackbit[g][i], (i == nexp - 1) ? last_ack : 1'b0);
      end
      check_eq({tag, "_stop"}, stop_seen[g], 1'b1);
   endtask

   initial begin : main
      int   lat;
      logic act;
      logic extra;
      reset = 1'b1;
      start_w = '{1'b0, 1'b0};
      sl_addr = 7'h21;
      payload0 = 16'h1234;
      payload1 = 32'h3008_0A82;
      stretch_at = '{-1, -1};
      nack_byte = '{-1, -1};
      repeat (3) @(negedge clk);
      check_eq("rst_scl_oe", scl_oe_w[0], 1'b0);
      check_eq("rst_sda_oe", sda_oe_w[0], 1'b0);
      check_eq("rst_busy",   busy_w[0],   1'b0);
      check_eq("rst_done",   done_w[0],   1'b0);
      check_eq("rst_nack",   nack_w[0],   1'b0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Address + reg + data, all ACKed
      exp_b = '{8'h42, 8'h12, 8'h34, 8'h00, 8'h00};
      run_xfer("t1", 0, -10, lat, act);
      check_eq("t1_latency", lat, 456);
      check_eq("t1_nack", nack_w[0], 1'b0);
      check_bus("t1", 0, 3, 1'b0);
      @(negedge clk);
      check_eq("t1_done_pulse", done_w[0], 1'b0);

      // Address NACKed: abort after first byte, nack held
      nack_byte[0] = 0;
      run_xfer("t2", 0, -10, lat, act);
      check_eq("t2_nack", nack_w[0], 1'b1);
      check_bus("t2", 0, 1, 1'b1);
      repeat (20) @(negedge clk);
      check_eq("t2_nack_hold", nack_w[0], 1'b1);
      nack_byte[0] = -1;

      // Delay command
      payload0 = 16'hFFFF;
      run_xfer("t3", 0, -10, lat, act);
      check_eq("t3_latency", lat, 3200);
      check_eq("t3_bus_idle", act, 1'b0);
      check_eq("t3_nack", nack_w[0], 1'b0);
      payload0 = 16'h1234;

      // Clock stretch on bit 3 of the address byte
      stretch_at[0] = 3;
      run_xfer("t4", 0, -10, lat, act);
      check_eq("t4_latency", lat, 466);
      check_bus("t4", 0, 3, 1'b0);
      stretch_at[0] = -1;

      // start while busy is ignored
      run_xfer("t5a", 0, 100, lat, act);
      check_eq("t5a_latency", lat, 456);
      check_bus("t5a", 0, 3, 1'b0);
      extra = 1'b0;
      repeat (50) begin @(negedge clk); extra = extra | done_w[0] | busy_w[0]; end
      check_eq("t5a_no_second", extra, 1'b0);

      // Reset mid-byte
      @(negedge clk); start_w[0] = 1'b1;
      @(negedge clk); start_w[0] = 1'b0;
      repeat (60) @(negedge clk);
      check_eq("t5b_pre_rst_scl", scl_oe_w[0], 1'b1);
      reset = 1'b1;
      @(negedge clk);
      check_eq("t5b_rst_scl_oe", scl_oe_w[0], 1'b0);
      check_eq("t5b_rst_sda_oe", sda_oe_w[0], 1'b0);
      check_eq("t5b_rst_busy",   busy_w[0],   1'b0);
      check_eq("t5b_rst_done",   done_w[0],   1'b0);
      reset = 1'b0;
      extra = 1'b0;
      repeat (30) begin @(negedge clk); extra = extra | done_w[0] | busy_w[0]; end
      check_eq("t5b_quiet", extra, 1'b0);
      run_xfer("t5c", 0, -10, lat, act);
      check_eq("t5c_latency", lat, 456);
      check_bus("t5c", 0, 3, 1'b0);

      // Two reg-address bytes, two data bytes
      exp_b = '{8'h42, 8'h30, 8'h08, 8'h0A, 8'h82};
      run_xfer("t6", 1, -10, lat, act);
      check_eq("t6_latency", lat, 744);
      check_eq("t6_nack", nack_w[1], 1'b0);
      check_bus("t6", 1, 5, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
